// File: rtl/tl45_pkg.sv
// Shared tl45 decode constants and scoreboard state type.
// The TL45_SB_FORWARD_EN build option is consumed by tl45_scoreboard.
package tl45_pkg;

    localparam logic [4:0] OP_NOP  = 5'h00;
    localparam logic [4:0] OP_LW   = 5'h14;
    localparam logic [4:0] OP_SW   = 5'h15;
    localparam logic [4:0] OP_CALL = 5'h0D;
    localparam logic [4:0] OP_RET  = 5'h0E;
    localparam logic [3:0] REG_SP  = 4'hF;

    typedef enum logic {SB_RUN, SB_DRAIN} sb_state_t;

endpackage

// File: rtl/tl45_sb_pend_ctr.sv
// Per-register pending-write counter. A simultaneous increment and decrement
// cancel. A decrement at zero holds the count at zero and flags underflow.
module tl45_sb_pend_ctr #(
    parameter int unsigned CNT_W = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_nonzero,
    output logic o_underflow
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d       = cnt_q;
        o_underflow = 1'b0;
        if (i_inc && !i_dec) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (i_dec && !i_inc) begin
            if (cnt_q == '0) begin
                o_underflow = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_nonzero = (cnt_q != '0);

endmodule

// File: rtl/tl45_scoreboard.sv
// tl45 issue scoreboard: stalls decode on register hazards, a full pipe or flush drain.
// When TL45_SB_FORWARD_EN is defined, only loads in flight block their readers.
module tl45_scoreboard
    import tl45_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = 3,
    parameter int unsigned CNT_W        = 2,
    parameter int unsigned PERF_W       = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_dec_valid,
    input  logic [4:0]        i_dec_opcode,
    input  logic [3:0]        i_dec_dr,
    input  logic [3:0]        i_dec_sr1,
    input  logic [3:0]        i_dec_sr2,
    input  logic              i_ex_stall,
    input  logic              i_flush,
    input  logic              i_wb_valid,
    input  logic [3:0]        i_wb_dr,
    output logic              o_pipe_stall,
    output logic              o_issue,
    output logic [CNT_W-1:0]  o_inflight,
    output logic [PERF_W-1:0] o_stall_count,
    output logic              o_sb_err
);

    sb_state_t         state_q, state_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [PERF_W-1:0] stall_q, stall_d;
    logic              err_q, err_d;
    logic              infl_uf;
    logic              hazard, full;

    logic [15:1] pend_inc, pend_dec, pend_nz, pend_uf;
    logic [15:0] pend;

    assign pend = {pend_nz, 1'b0};

    for (genvar r = 1; r < 16; r++) begin : g_pend
        assign pend_inc[r] = o_issue && (i_dec_dr == 4'(r));
        assign pend_dec[r] = i_wb_valid && (i_wb_dr == 4'(r));

        tl45_sb_pend_ctr #(
            .CNT_W (CNT_W)
        ) u_ctr (
            .i_clk       (i_clk),
            .i_reset     (i_reset),
            .i_inc       (pend_inc[r]),
            .i_dec       (pend_dec[r]),
            .o_nonzero   (pend_nz[r]),
            .o_underflow (pend_uf[r])
        );
    end

`ifdef TL45_SB_FORWARD_EN
    logic [15:1] load_pend_q, load_pend_d;
    logic [15:0] load_blk;

    // A stale load bit is masked by the zero count and dropped on the next edge.
    assign load_blk = {load_pend_q & pend_nz, 1'b0};
    assign hazard   = load_blk[i_dec_sr1] | load_blk[i_dec_sr2];

    always_comb begin
        load_pend_d = load_pend_q & pend_nz;
        for (int unsigned r = 1; r < 16; r++) begin
            if (o_issue && (i_dec_opcode == OP_LW) && (i_dec_dr == 4'(r))) begin
                load_pend_d[r] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            load_pend_q <= '0;
        end else begin
            load_pend_q <= load_pend_d;
        end
    end
`else
    logic unused_opcode;

    assign unused_opcode = ^i_dec_opcode;
    assign hazard = pend[i_dec_sr1] | pend[i_dec_sr2] | pend[i_dec_dr];
`endif

    assign full = (inflight_q == CNT_W'(MAX_INFLIGHT)) && !i_wb_valid;

    always_comb begin
        o_issue = 1'b0;
        if (state_q == SB_RUN) begin
            o_issue = i_dec_valid && !hazard && !full && !i_ex_stall && !i_flush;
        end
        o_pipe_stall = i_dec_valid && !o_issue;
    end

    always_comb begin
        inflight_d = inflight_q;
        infl_uf    = 1'b0;
        if (o_issue && !i_wb_valid) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (i_wb_valid && !o_issue) begin
            if (inflight_q == '0) begin
                infl_uf = 1'b1;
            end else begin
                inflight_d = inflight_q - CNT_W'(1);
            end
        end

        state_d = state_q;
        case (state_q)
            SB_RUN:   if (i_flush) state_d = SB_DRAIN;
            SB_DRAIN: if (!i_flush && (inflight_q == '0)) state_d = SB_RUN;
            default:  state_d = SB_RUN;
        endcase

        stall_d = stall_q;
        if (o_pipe_stall && (stall_q != '1)) begin
            stall_d = stall_q + PERF_W'(1);
        end

        err_d = err_q | (|pend_uf) | infl_uf;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= SB_RUN;
            inflight_q <= '0;
            stall_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            stall_q    <= stall_d;
            err_q      <= err_d;
        end
    end

    assign o_inflight    = inflight_q;
    assign o_stall_count = stall_q;
    assign o_sb_err      = err_q;

endmodule

// File: tb/tb_tl45_scoreboard.sv
// Bench for tl45_scoreboard: directed scenarios plus random traffic checked
// against an integer-level scoreboard model (follows TL45_SB_FORWARD_EN).
module tb_tl45_scoreboard;

    localparam int MAXI = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid;
    logic [4:0]  dec_op;
    logic [3:0]  dec_dr, dec_sr1, dec_sr2;
    logic        ex_stall, flush, wb_valid;
    logic [3:0]  wb_dr;
    logic        pipe_stall, issue, sb_err;
    logic [1:0]  inflight;
    logic [31:0] stall_count;

    int total = 0;
    int bad   = 0;

    tl45_scoreboard #(
        .MAX_INFLIGHT (3),
        .CNT_W        (2),
        .PERF_W       (32)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_dec_valid   (dec_valid),
        .i_dec_opcode  (dec_op),
        .i_dec_dr      (dec_dr),
        .i_dec_sr1     (dec_sr1),
        .i_dec_sr2     (dec_sr2),
        .i_ex_stall    (ex_stall),
        .i_flush       (flush),
        .i_wb_valid    (wb_valid),
        .i_wb_dr       (wb_dr),
        .o_pipe_stall  (pipe_stall),
        .o_issue       (issue),
        .o_inflight    (inflight),
        .o_stall_count (stall_count),
        .o_sb_err      (sb_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: plain integer counts per register and in-order retire queue.
    int          m_pend[16];
    bit          m_lp[16];
    int          m_infl;
    bit          m_drain;
    longint      m_stalls;
    bit          m_err;
    int          m_q[$];
    bit          e_issue, e_stall;

    function automatic void m_clear();
        for (int r = 0; r < 16; r++) begin
            m_pend[r] = 0;
            m_lp[r]   = 0;
        end
        m_infl   = 0;
        m_drain  = 0;
        m_stalls = 0;
        m_err    = 0;
        m_q.delete();
    endfunction

    function automatic bit m_busy(input int r);
        if (r == 0) return 0;
`ifdef TL45_SB_FORWARD_EN
        return m_lp[r];
`else
        return m_pend[r] > 0;
`endif
    endfunction

    function automatic void m_predict();
        bit hz, full;
`ifdef TL45_SB_FORWARD_EN
        hz = m_busy(int'(dec_sr1)) || m_busy(int'(dec_sr2));
`else
        hz = m_busy(int'(dec_sr1)) || m_busy(int'(dec_sr2)) || m_busy(int'(dec_dr));
`endif
        full    = (m_infl == MAXI) && !wb_valid;
        e_issue = !m_drain && dec_valid && !hz && !full && !ex_stall && !flush;
        e_stall = dec_valid && !e_issue;
    endfunction

    function automatic void m_update();
        int n;
        if (rst) begin
            m_clear();
            return;
        end
        if (m_drain) m_drain = flush || (m_infl != 0);
        else         m_drain = flush;
        n = m_infl + int'(e_issue) - int'(wb_valid);
        if (n < 0) begin m_err = 1; n = 0; end
        m_infl = n;
        for (int r = 1; r < 16; r++) begin
            n = m_pend[r] + int'(e_issue && dec_dr == r) - int'(wb_valid && wb_dr == r);
            if (n < 0) begin m_err = 1; n = 0; end
            m_pend[r] = n;
            if (n == 0) m_lp[r] = 0;
        end
        if (e_issue && dec_op == 5'h14 && dec_dr != 0) m_lp[dec_dr] = 1;
        if (e_stall && m_stalls < 64'hFFFF_FFFF) m_stalls++;
        if (wb_valid && m_q.size() > 0) void'(m_q.pop_front());
        if (e_issue) m_q.push_back(int'(dec_dr));
    endfunction

    task automatic set_in(input bit v, input logic [4:0] op, input logic [3:0] dr,
                          input logic [3:0] s1, input logic [3:0] s2, input bit exs,
                          input bit fl, input bit wbv, input logic [3:0] wbd);
        dec_valid = v; dec_op = op; dec_dr = dr; dec_sr1 = s1; dec_sr2 = s2;
        ex_stall = exs; flush = fl; wb_valid = wbv; wb_dr = wbd;
    endtask

    // Inputs are applied 1ns after the rising edge; outputs are sampled 2ns later.
    task automatic tick(input string tag);
        #2;
        m_predict();
        check_eq({tag, ".issue"},    32'(issue),       32'(e_issue));
        check_eq({tag, ".stall"},    32'(pipe_stall),  32'(e_stall));
        check_eq({tag, ".inflight"}, 32'(inflight),    32'(m_infl));
        check_eq({tag, ".stallcnt"}, stall_count,      32'(m_stalls));
        check_eq({tag, ".err"},      32'(sb_err),      32'(m_err));
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(0, 5'h00, 0, 0, 0, 0, 0, 0, 0);
        tick("rst");
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 5'h00, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        m_clear();
        do_reset();

        // RAW on r1 held until the cycle after its retire
        set_in(1, 5'h01, 1, 2, 3, 0, 0, 0, 0); tick("t1_add1");
        set_in(1, 5'h01, 2, 1, 3, 0, 0, 0, 0); tick("t1_dep0");
        tick("t1_dep1");
        set_in(1, 5'h01, 2, 1, 3, 0, 0, 1, 1); tick("t1_wb1");
        set_in(1, 5'h01, 2, 1, 3, 0, 0, 0, 0); tick("t1_dep2");
        set_in(0, 5'h00, 0, 0, 0, 0, 0, 1, 2); tick("t1_wb2");
        set_in(0, 5'h00, 0, 0, 0, 0, 0, 0, 0); tick("t1_idle");

        // load-use on r4
        set_in(1, 5'h14, 4, 5, 0, 0, 0, 0, 0); tick("t2_lw");
        set_in(1, 5'h01, 5, 4, 0, 0, 0, 0, 0); tick("t2_use0");
        tick("t2_use1");
        tick("t2_use2");
        set_in(1, 5'h01, 5, 4, 0, 0, 0, 1, 4); tick("t2_wb4");
        set_in(1, 5'h01, 5, 4, 0, 0, 0, 0, 0); tick("t2_use3");
        set_in(0, 5'h00, 0, 0, 0, 0, 0, 1, 5); tick("t2_wb5");
        set_in(0, 5'h00, 0, 0, 0, 0, 0, 0, 0); tick("t2_idle");

        // structural full and same-cycle retire
        do_reset();
        set_in(1, 5'h01, 1, 0, 0, 0, 0, 0, 0); tick("t3_i1");
        set_in(1, 5'h01, 2, 0, 0, 0, 0, 0, 0); tick("t3_i2");
        set_in(1, 5'h01, 3, 0, 0, 0, 0, 0, 0); tick("t3_i3");
        set_in(1, 5'h01, 4, 0, 0, 0, 0, 0, 0); tick("t3_full0");
        tick("t3_full1");
        set_in(1, 5'h01, 4, 0, 0, 0, 0, 1, 1); tick("t3_swap");
        check_eq("t3_infl_max", 32'(inflight), 32'd3);
        set_in(0, 5'h00, 0, 0, 0, 0, 0, 1, 2); tick("t3_wb2");
        set_in(0, 5'h00, 0, 0, 0, 0, 0, 1, 3); tick("t3_wb3");
        set_in(0, 5'h00, 0, 0, 0, 0, 0, 1, 4); tick("t3_wb4");

        // flush drain with two in flight
        do_reset();
        set_in(1, 5'h01, 1, 0, 0, 0, 0, 0, 0); tick("t4_i1");
        set_in(1, 5'h01, 2, 0, 0, 0, 0, 0, 0); tick("t4_i2");
        set_in(1, 5'h01, 3, 0, 0, 0, 1, 0, 0); tick("t4_flush");
        set_in(1, 5'h01, 3, 0, 0, 0, 0, 0, 0); tick("t4_drain0");
        tick("t4_drain1");
        set_in(1, 5'h01, 3, 0, 0, 0, 0, 1, 1); tick("t4_wb1");
        set_in(1, 5'h01, 3, 0, 0, 0, 0, 1, 2); tick("t4_wb2");
        set_in(1, 5'h01, 3, 0, 0, 0, 0, 0, 0); tick("t4_empty");
        tick("t4_run");
        set_in(0, 5'h00, 0, 0, 0, 0, 0, 1, 3); tick("t4_wb3");

        // same-register inc/dec and underflow error
        do_reset();
        set_in(1, 5'h01, 7, 0, 0, 0, 0, 0, 0); tick("t5_i7");
        set_in(1, 5'h01, 7, 0, 0, 0, 0, 1, 7); tick("t5_incdec");
        set_in(1, 5'h01, 8, 7, 0, 0, 0, 0, 0); tick("t5_rd7");
        set_in(0, 5'h00, 0, 0, 0, 0, 0, 1, 9); tick("t5_uf9");
        set_in(0, 5'h00, 0, 0, 0, 0, 0, 0, 0); tick("t5_sticky0");
        tick("t5_sticky1");

        // reset in the middle of a hazard stall
        set_in(1, 5'h01, 15, 0, 0, 0, 0, 0, 0); tick("t6_i15");
        set_in(1, 5'h0D, 0, 0, 15, 0, 0, 0, 0); tick("t6_call0");
        tick("t6_call1");
        rst = 1'b1;                              tick("t6_rst");
        rst = 1'b0;                              tick("t6_after");
        check_eq("t6_err_clear", 32'(sb_err), 32'd0);

        // random traffic with in-order retires of issued instructions
        do_reset();
        for (int c = 0; c < 800; c++) begin
            logic [4:0] op;
            bit wbv;
            op  = ($urandom % 4 == 0) ? 5'h14 : 5'($urandom_range(1, 31));
            wbv = (m_q.size() > 0) && ($urandom % 2 == 0);
            set_in($urandom % 4 != 0, op, 4'($urandom), 4'($urandom % 3 == 0 ? 0 : $urandom),
                   4'($urandom % 3 == 0 ? 0 : $urandom), $urandom % 8 == 0,
                   $urandom % 20 == 0, wbv, wbv ? 4'(m_q[0]) : 4'($urandom));
            rst = ($urandom % 200 == 0);
            tick("rnd");
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
